// File: rtl/stage3_ex_pkg.sv
// rtl/stage3_ex_pkg.sv - shared encodings for the EX stage and its mul/div unit
package stage3_ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // mul/div op is the low two funct bits of the launching instruction
    localparam logic [1:0] MDOP_MULT  = FN_MULT[1:0];
    localparam logic [1:0] MDOP_MULTU = FN_MULTU[1:0];
    localparam logic [1:0] MDOP_DIV   = FN_DIV[1:0];
    localparam logic [1:0] MDOP_DIVU  = FN_DIVU[1:0];

    typedef struct packed {
        logic branch;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } ctl_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == FN_MULT[5:2];
    endfunction

endpackage

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative 32-cycle multiplier/divider holding HI/LO
module muldiv
    import stage3_ex_pkg::*;
#(
    parameter logic [31:0] ZERO_DIV_LO = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    md_state_t   r_state, w_next;
    logic [1:0]  r_op;
    logic [4:0]  r_cnt;
    logic [31:0] r_wh, r_wl, r_b, r_hi, r_lo;
    logic        r_neg_q, r_neg_r, r_bzero;
    logic        w_signed, w_div, w_ge;
    logic [31:0] w_mag_a, w_mag_b, w_nwh, w_nwl, w_fin_hi, w_fin_lo;
    logic [32:0] w_sum, w_rsh, w_diff;
    logic [63:0] w_prod;

    assign w_signed = (op == MDOP_MULT) || (op == MDOP_DIV);
    assign w_mag_a  = (w_signed && a[31]) ? -a : a;
    assign w_mag_b  = (w_signed && b[31]) ? -b : b;
    assign w_div    = (r_op == MDOP_DIV) || (r_op == MDOP_DIVU);

    // {r_wh, r_wl} is the shift-add product or the {remainder, quotient} pair
    assign w_sum  = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : 33'd0);
    assign w_rsh  = {r_wh, r_wl[31]};
    assign w_diff = w_rsh - {1'b0, r_b};
    assign w_ge   = !w_diff[32];
    assign w_nwh  = w_div ? (w_ge ? w_diff[31:0] : w_rsh[31:0]) : w_sum[32:1];
    assign w_nwl  = w_div ? {r_wl[30:0], w_ge} : {w_sum[0], r_wl[31:1]};
    assign w_prod = {w_nwh, w_nwl};

    always_comb begin
        if (w_div) begin
            w_fin_lo = r_bzero ? ZERO_DIV_LO : (r_neg_q ? -w_nwl : w_nwl);
            w_fin_hi = r_neg_r ? -w_nwh : w_nwh;
        end else begin
            {w_fin_hi, w_fin_lo} = r_neg_q ? -w_prod : w_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MD_IDLE: if (start) w_next = MD_RUN;
            MD_RUN:  if (r_cnt == 5'd31) w_next = MD_DONE;
            default: w_next = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != MD_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= '0;
            r_cnt   <= '0;
            r_wh    <= '0;
            r_wl    <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bzero <= 1'b0;
        end else if (r_state == MD_IDLE && start) begin
            r_op    <= op;
            r_cnt   <= '0;
            r_wh    <= '0;
            r_wl    <= w_mag_a;
            r_b     <= w_mag_b;
            r_neg_q <= w_signed && (a[31] ^ b[31]);
            r_neg_r <= w_signed && a[31];
            r_bzero <= (b == 32'd0);
        end else if (r_state == MD_RUN) begin
            r_cnt <= r_cnt + 5'd1;
            r_wh  <= w_nwh;
            r_wl  <= w_nwl;
            if (r_cnt == 5'd31) begin
                r_hi <= w_fin_hi;
                r_lo <= w_fin_lo;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: rtl/stage3_ex.sv
// rtl/stage3_ex.sv - pipeline EX stage: operand muxes, ALU, branch target and mul/div hookup
module stage3_ex
    import stage3_ex_pkg::*;
#(
    parameter logic [31:0] ZERO_DIV_LO = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        stall,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] seimm,
    input  logic [1:0]  aluop,
    input  logic        alusrc,
    input  logic        regdst,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [31:0] pc4,
    input  logic [4:0]  ctl,
    output logic [31:0] alurslt,
    output logic [31:0] data2_out,
    output logic [31:0] baddr,
    output logic        zero,
    output logic [4:0]  ctl_out,
    output logic [4:0]  wrreg
);
    logic [5:0]  w_funct;
    logic [31:0] w_opb, w_result, w_hi, w_lo;
    logic        w_rtype, w_launch, w_mf, w_busy, w_start;
    logic [31:0] r_alurslt, r_data2, r_baddr;
    logic        r_zero;
    ctl_t        r_ctl;
    logic [4:0]  r_wrreg;

    assign w_funct  = seimm[5:0];
    assign w_opb    = alusrc ? seimm : data2;
    assign w_rtype  = (aluop == ALUOP_FUNCT);
    assign w_launch = w_rtype && is_muldiv(w_funct);
    assign w_mf     = w_rtype && (w_funct == FN_MFHI || w_funct == FN_MFLO);
    // only instructions that touch HI/LO or the unit wait; everything else flows
    assign stall    = w_busy && (w_launch || w_mf);
    assign w_start  = w_launch && !stall;

    always_comb begin
        w_result = '0;
        case (aluop)
            ALUOP_ADD: w_result = data1 + w_opb;
            ALUOP_SUB: w_result = data1 - w_opb;
            ALUOP_OR:  w_result = data1 | w_opb;
            default: begin
                case (w_funct)
                    FN_ADD, FN_ADDU: w_result = data1 + w_opb;
                    FN_SUB, FN_SUBU: w_result = data1 - w_opb;
                    FN_AND:  w_result = data1 & w_opb;
                    FN_OR:   w_result = data1 | w_opb;
                    FN_XOR:  w_result = data1 ^ w_opb;
                    FN_NOR:  w_result = ~(data1 | w_opb);
                    FN_SLT:  w_result = {31'd0, $signed(data1) < $signed(w_opb)};
                    FN_SLTU: w_result = {31'd0, data1 < w_opb};
                    FN_MFHI: w_result = w_hi;
                    FN_MFLO: w_result = w_lo;
                    default: w_result = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alurslt <= '0;
            r_data2   <= '0;
            r_baddr   <= '0;
            r_zero    <= 1'b0;
            r_ctl     <= '0;
            r_wrreg   <= '0;
        end else if (stall) begin
            r_ctl   <= '0;
            r_wrreg <= '0;
        end else begin
            r_alurslt <= w_result;
            r_data2   <= data2;
            r_baddr   <= pc4 + {seimm[29:0], 2'b00};
            r_zero    <= (w_result == 32'd0);
            r_ctl     <= ctl_t'(ctl);
            r_wrreg   <= regdst ? rd : rt;
        end
    end

    muldiv #(
        .ZERO_DIV_LO(ZERO_DIV_LO)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .op    (w_funct[1:0]),
        .a     (data1),
        .b     (data2),
        .busy  (w_busy),
        .hi    (w_hi),
        .lo    (w_lo)
    );

    assign alurslt   = r_alurslt;
    assign data2_out = r_data2;
    assign baddr     = r_baddr;
    assign zero      = r_zero;
    assign ctl_out   = r_ctl;
    assign wrreg     = r_wrreg;

endmodule
